// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video constants and helpers for the edge/bbox stage
package video_pkg;

  localparam int DEFAULT_CNT_W = 11;

  localparam logic [7:0] Y_WHITE   = 8'hEB;
  localparam logic [7:0] Y_BLACK   = 8'h10;
  localparam logic [7:0] C_NEUTRAL = 8'h80;

  localparam logic [23:0] DEFAULT_BOX_COLOR = {Y_WHITE, C_NEUTRAL, C_NEUTRAL};

  // 8-bit result so that -64 maps to +64 without wrapping
  function automatic logic [7:0] abs7(input logic [6:0] s);
    logic [7:0] ext;
    ext = {s[6], s};
    return s[6] ? (8'd0 - ext) : ext;
  endfunction

endpackage

// File: rtl/edge_bbox_acc.sv
// rtl/edge_bbox_acc.sv - per-frame edge bbox/count accumulators and frame-end latch
module edge_bbox_acc
  import video_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               is_edge,
  input  logic [CNT_W-1:0]   x,
  input  logic [CNT_W-1:0]   y,
  input  logic               frame_end,
  output logic [CNT_W-1:0]   x_min,
  output logic [CNT_W-1:0]   x_max,
  output logic [CNT_W-1:0]   y_min,
  output logic [CNT_W-1:0]   y_max,
  output logic [2*CNT_W-1:0] edge_count,
  output logic               bbox_valid
);

  logic [CNT_W-1:0]   acc_x_min, acc_x_max, acc_y_min, acc_y_max;
  logic [2*CNT_W-1:0] acc_count;
  logic               have_edges;

  assign have_edges = (acc_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_x_min  <= '1;
      acc_x_max  <= '0;
      acc_y_min  <= '1;
      acc_y_max  <= '0;
      acc_count  <= '0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      edge_count <= '0;
      bbox_valid <= 1'b0;
    end else if (frame_end) begin
      bbox_valid <= have_edges;
      edge_count <= acc_count;
      x_min      <= have_edges ? acc_x_min : '0;
      x_max      <= have_edges ? acc_x_max : '0;
      y_min      <= have_edges ? acc_y_min : '0;
      y_max      <= have_edges ? acc_y_max : '0;
      // An edge on the frame-end cycle seeds the fresh frame
      if (is_edge) begin
        acc_x_min <= x;
        acc_x_max <= x;
        acc_y_min <= y;
        acc_y_max <= y;
        acc_count <= {{(2*CNT_W-1){1'b0}}, 1'b1};
      end else begin
        acc_x_min <= '1;
        acc_x_max <= '0;
        acc_y_min <= '1;
        acc_y_max <= '0;
        acc_count <= '0;
      end
    end else if (is_edge) begin
      if (x < acc_x_min) acc_x_min <= x;
      if (x > acc_x_max) acc_x_max <= x;
      if (y < acc_y_min) acc_y_min <= y;
      if (y > acc_y_max) acc_y_max <= y;
      if (acc_count != '1) acc_count <= acc_count + 1'b1;
    end
  end

endmodule

// File: rtl/edge_bbox_overlay.sv
// rtl/edge_bbox_overlay.sv - gradient threshold to edge map with previous-frame bbox overlay
module edge_bbox_overlay
  import video_pkg::*;
#(
  parameter int          CNT_W     = DEFAULT_CNT_W,
  parameter logic [7:0]  EDGE_Y    = Y_WHITE,
  parameter logic [7:0]  BG_Y      = Y_BLACK,
  parameter logic [23:0] BOX_COLOR = DEFAULT_BOX_COLOR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [23:0]        pixel_in,
  input  logic               de_in,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic [6:0]         thr,
  output logic               de_out,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic [23:0]        pixel_out,
  output logic [CNT_W-1:0]   x_min,
  output logic [CNT_W-1:0]   x_max,
  output logic [CNT_W-1:0]   y_min,
  output logic [CNT_W-1:0]   y_max,
  output logic [2*CNT_W-1:0] edge_count,
  output logic               bbox_valid
);

  logic [CNT_W-1:0] x_cnt, y_cnt, y_cur;
  logic             de_prev, vs_prev;
  logic             frame_end, is_edge, on_box;
  logic [7:0]       mag;

  assign frame_end = v_sync_in && !vs_prev;
  // The frame-end pixel already belongs to the new frame, so its row is 0
  assign y_cur     = frame_end ? '0 : y_cnt;
  assign mag       = abs7(pixel_in[22:16]);
  assign is_edge   = de_in && (mag >= {1'b0, thr});

  assign on_box = bbox_valid &&
                  (((x_cnt == x_min || x_cnt == x_max) && y_cur >= y_min && y_cur <= y_max) ||
                   ((y_cur == y_min || y_cur == y_max) && x_cnt >= x_min && x_cnt <= x_max));

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      de_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_out  <= '0;
    end else begin
      de_prev    <= de_in;
      vs_prev    <= v_sync_in;
      de_out     <= de_in;
      h_sync_out <= h_sync_in;
      v_sync_out <= v_sync_in;

      if (!de_in)             x_cnt <= '0;
      else if (x_cnt != '1)   x_cnt <= x_cnt + 1'b1;

      if (frame_end)                          y_cnt <= '0;
      else if (de_prev && !de_in && y_cnt != '1) y_cnt <= y_cnt + 1'b1;

      if (!de_in)      pixel_out <= '0;
      else if (on_box) pixel_out <= BOX_COLOR;
      else             pixel_out <= {is_edge ? EDGE_Y : BG_Y, C_NEUTRAL, C_NEUTRAL};
    end
  end

  edge_bbox_acc #(.CNT_W(CNT_W)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .is_edge    (is_edge),
    .x          (x_cnt),
    .y          (y_cur),
    .frame_end  (frame_end),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .edge_count (edge_count),
    .bbox_valid (bbox_valid)
  );

endmodule

// File: tb/tb_edge_bbox_overlay.sv
// tb/tb_edge_bbox_overlay.sv - directed bench with frame-level reference model
module tb_edge_bbox_overlay;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pixel_in;
  logic        de_in, h_sync_in, v_sync_in;
  logic [6:0]  thr;
  logic        de_out, h_sync_out, v_sync_out;
  logic [23:0] pixel_out;
  logic [10:0] x_min, x_max, y_min, y_max;
  logic [21:0] edge_count;
  logic        bbox_valid;

  always #5 clk = ~clk;

  edge_bbox_overlay dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_in   (pixel_in),
    .de_in      (de_in),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .thr        (thr),
    .de_out     (de_out),
    .h_sync_out (h_sync_out),
    .v_sync_out (v_sync_out),
    .pixel_out  (pixel_out),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .edge_count (edge_count),
    .bbox_valid (bbox_valid)
  );

  int vecs = 0;
  int errs = 0;

  // Frame-level model: pixel coordinates plus the list of edge points seen this frame
  int m_x, m_y;
  bit m_de_prev, m_vs_prev;
  int q_x[$];
  int q_y[$];
  int l_xmin, l_xmax, l_ymin, l_ymax, l_cnt;
  bit l_valid;
  logic [23:0] e_pix;
  bit e_de, e_hs, e_vs;

  logic [6:0]  grad [0:7][0:7];
  logic [23:0] img  [0:7][0:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_de_prev = 0; m_vs_prev = 0;
    q_x.delete(); q_y.delete();
    l_xmin = 0; l_xmax = 0; l_ymin = 0; l_ymax = 0; l_cnt = 0; l_valid = 0;
  endtask

  task automatic step(input bit r, input bit de, input bit hs, input bit vs, input logic [6:0] s);
    int cx, cy, sv, mag;
    bit fe, e, on;
    rst = r; de_in = de; h_sync_in = hs; v_sync_in = vs;
    pixel_in = {1'b1, s, 16'hA55A};
    cx = 0; cy = 0;
    if (r) begin
      model_reset();
      e_pix = 0; e_de = 0; e_hs = 0; e_vs = 0;
    end else begin
      fe = vs && !m_vs_prev;
      cx = m_x;
      cy = fe ? 0 : m_y;
      sv = s[6] ? int'(s) - 128 : int'(s);
      mag = (sv < 0) ? -sv : sv;
      e = de && (mag >= int'(thr));
      on = l_valid &&
           (((cx == l_xmin || cx == l_xmax) && cy >= l_ymin && cy <= l_ymax) ||
            ((cy == l_ymin || cy == l_ymax) && cx >= l_xmin && cx <= l_xmax));
      e_pix = !de ? 24'h0 : on ? 24'hEB8080 : {(e ? 8'hEB : 8'h10), 16'h8080};
      e_de = de; e_hs = hs; e_vs = vs;
      if (fe) begin
        l_cnt = q_x.size();
        l_valid = (l_cnt != 0);
        l_xmin = 0; l_xmax = 0; l_ymin = 0; l_ymax = 0;
        if (l_valid) begin
          l_xmin = 2047; l_ymin = 2047;
          foreach (q_x[i]) begin
            if (q_x[i] < l_xmin) l_xmin = q_x[i];
            if (q_x[i] > l_xmax) l_xmax = q_x[i];
            if (q_y[i] < l_ymin) l_ymin = q_y[i];
            if (q_y[i] > l_ymax) l_ymax = q_y[i];
          end
        end
        q_x.delete(); q_y.delete();
      end
      if (e) begin q_x.push_back(cx); q_y.push_back(cy); end
      m_x = de ? ((m_x < 2047) ? m_x + 1 : 2047) : 0;
      if (fe) m_y = 0;
      else if (m_de_prev && !de && m_y < 2047) m_y++;
      m_de_prev = de;
      m_vs_prev = vs;
    end
    @(posedge clk);
    #1;
    chk("pixel_out", pixel_out, e_pix);
    chk("de_out", de_out, e_de);
    chk("h_sync_out", h_sync_out, e_hs);
    chk("v_sync_out", v_sync_out, e_vs);
    chk("bbox_valid", bbox_valid, l_valid);
    chk("x_min", x_min, l_xmin);
    chk("x_max", x_max, l_xmax);
    chk("y_min", y_min, l_ymin);
    chk("y_max", y_max, l_ymax);
    chk("edge_count", edge_count, l_cnt);
    if (!r && de && cx < 8 && cy < 8) img[cy][cx] = pixel_out;
  endtask

  task automatic clear_grad();
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 8; xx++)
        grad[yy][xx] = 7'h00;
  endtask

  task automatic lines(input int w, input int h);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) step(0, 1, 0, 0, grad[yy][xx]);
      step(0, 0, 1, 0, 7'h00);
      step(0, 0, 0, 0, 7'h00);
    end
  endtask

  task automatic frame(input int w, input int h);
    lines(w, h);
    step(0, 0, 0, 1, 7'h00);
    step(0, 0, 0, 1, 7'h00);
    step(0, 0, 0, 0, 7'h00);
  endtask

  task automatic chk_stats(input string tag, input int xa, input int xb, input int ya,
                           input int yb, input int cnt, input bit v);
    chk({tag, ".x_min"}, x_min, xa);
    chk({tag, ".x_max"}, x_max, xb);
    chk({tag, ".y_min"}, y_min, ya);
    chk({tag, ".y_max"}, y_max, yb);
    chk({tag, ".edge_count"}, edge_count, cnt);
    chk({tag, ".bbox_valid"}, bbox_valid, v);
  endtask

  initial begin
    thr = 7'd0;
    model_reset();
    clear_grad();

    // Reset, then an idle stream and one vsync
    step(1, 0, 0, 0, 7'h00);
    step(1, 0, 0, 0, 7'h00);
    chk("reset.pixel_out", pixel_out, 24'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 7'h00);
    step(0, 0, 0, 1, 7'h00);
    step(0, 0, 0, 0, 7'h00);
    chk_stats("idle", 0, 0, 0, 0, 0, 0);

    // Single edge at (3,2)
    thr = 7'd10;
    grad[2][3] = 7'd12;
    frame(8, 4);
    chk_stats("single", 3, 3, 2, 2, 1, 1);

    // -64 vs -63 against thr=64
    thr = 7'd64;
    clear_grad();
    grad[0][0] = 7'h40;
    grad[0][1] = 7'h41;
    frame(8, 4);
    chk("neg64.pixel", img[0][0], 24'hEB8080);
    chk("neg63.pixel", img[0][1], 24'h108080);
    chk_stats("neg", 0, 0, 0, 0, 1, 1);

    // Build bbox (1,1)-(4,3), then overlay it on a flat frame
    thr = 7'd10;
    clear_grad();
    grad[1][1] = 7'd20;
    grad[3][4] = 7'h70;
    frame(8, 4);
    chk_stats("box", 1, 4, 1, 3, 2, 1);
    clear_grad();
    frame(8, 4);
    chk("ovl(1,2)", img[2][1], 24'hEB8080);
    chk("ovl(4,1)", img[1][4], 24'hEB8080);
    chk("ovl(2,3)", img[3][2], 24'hEB8080);
    chk("ovl(2,2)", img[2][2], 24'h108080);
    chk("ovl(5,1)", img[1][5], 24'h108080);
    chk_stats("empty", 0, 0, 0, 0, 0, 0);
    frame(8, 4);
    chk("nobox(1,1)", img[1][1], 24'h108080);
    chk("nobox(4,3)", img[3][4], 24'h108080);

    // Reset in the middle of a frame discards the earlier edge
    grad[0][0] = 7'd20;
    lines(8, 1);
    step(1, 0, 0, 0, 7'h00);
    clear_grad();
    grad[3][5] = 7'd20;
    frame(8, 4);
    chk_stats("midrst", 5, 5, 3, 3, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
